// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: the entry
// format stored in the prefetch queue and the fetch word geometry.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of fetch entries with a flush that empties it in one
// edge; the head reads as a NOP entry with zero PCs whenever the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  fetch_entry_t         entry_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output fetch_entry_t         head_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [PW:0]    count_q, count_d;
    logic           do_push;
    logic           do_pop;

    // A flush voids both the incoming response and any pop in the same cycle.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= entry_i;
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[head_q]
                                     : '{instr: NOP_INSTR, pc: '0, pc4: '0};

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, issues word reads to a 1-cycle instruction memory,
// buffers responses in a prefetch queue and hands them to decode via valid/ready.
module instruction_fetch_queue #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4
);

    import fetch_pkg::*;

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
    localparam logic [XLEN-1:0] STEP  = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] issued_pc_q, issued_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            issue;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    fetch_entry_t    resp_entry;
    fetch_entry_t    head;

    // Branch wins over jump; targets are forced onto a word boundary.
    assign redirect  = branch_taken | jump_taken;
    assign target    = branch_taken ? {branch_target[XLEN-1:2], 2'b00}
                                    : {jump_target[XLEN-1:2], 2'b00};

    // The outstanding read already owns a slot, so it counts as occupied.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue     = reset && !redirect && (occupancy < DEPTH_W);

    always_comb begin
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = 1'b0;
        if (redirect) begin
            pc_d = target;
        end else if (issue) begin
            pc_d        = pc_q + STEP;
            issued_pc_d = pc_q;
            inflight_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q        <= {RESET_PC[XLEN-1:2], 2'b00};
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
        end
    end

    assign resp_entry = '{instr: imem_rdata, pc: issued_pc_q, pc4: issued_pc_q + STEP};
    assign pop        = out_valid && out_ready;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .entry_i (resp_entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .count_o (count),
        .head_o  (head)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign out_pc4   = head.pc4;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: a default instance plus one
// with a near-wrap reset PC, each fed by an address-as-data instruction memory.
module tb_instruction_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump_taken = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_target = '0;

    logic        imem_req, imem_req_w;
    logic [31:0] imem_addr, imem_addr_w;
    logic [31:0] imem_rdata, imem_rdata_w;
    logic        out_valid, out_valid_w;
    logic [31:0] out_instr, out_instr_w;
    logic [31:0] out_pc, out_pc_w;
    logic [31:0] out_pc4, out_pc4_w;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expQ [$];
    logic [31:0] expVal;

    instruction_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4)
    );

    instruction_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_instr(out_instr_w), .out_pc(out_pc_w), .out_pc4(out_pc4_w)
    );

    always #5 clk = ~clk;

    // Instruction memory returns the requested address as the instruction word.
    always @(posedge clk) begin
        imem_rdata   <= imem_addr;
        imem_rdata_w <= imem_addr_w;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle; also guards against a push into a full queue.
    task automatic step();
        if (reset && !branch_taken && !jump_taken) begin
            checks++;
            if (dut.u_queue.count_o == 3'd4 && dut.inflight_q && !(out_valid && out_ready)) begin
                failures++;
                $display("[TB] FAIL queue_overflow got push into full queue exp=no push");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0; out_ready = rdy;
        step(); step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; out_ready = 1'b0;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("[TB] FAIL rst_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("[TB] FAIL rst_pc got=%h exp=0", out_pc); end
        checks++; if (out_pc4 !== 32'h0) begin failures++; $display("[TB] FAIL rst_pc4 got=%h exp=0", out_pc4); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_addr got=%h exp=0", imem_addr); end
        checks++; if (imem_addr_w !== 32'hFFFF_FFF8) begin failures++; $display("[TB] FAIL rst_addr_w got=%h exp=fffffff8", imem_addr_w); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL c0_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL s_c0_addr got=%h exp=0", imem_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL s_c0_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL s_c1_valid got=%b exp=0", out_valid); end
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("[TB] FAIL s_c1_addr got=%h exp=4", imem_addr); end
        expQ.delete();
        for (int i = 0; i < 6; i++) expQ.push_back(32'(i * 4));
        for (int k = 2; k < 8; k++) begin
            step();
            expVal = expQ.pop_front();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL s_valid cycle %0d got=%b exp=1", k, out_valid); end
            checks++; if (out_pc !== expVal) begin failures++; $display("[TB] FAIL s_pc got=%h exp=%h", out_pc, expVal); end
            checks++; if (out_pc4 !== expVal + 32'd4) begin failures++; $display("[TB] FAIL s_pc4 got=%h exp=%h", out_pc4, expVal + 32'd4); end
            checks++; if (out_instr !== expVal) begin failures++; $display("[TB] FAIL s_instr got=%h exp=%h", out_instr, expVal); end
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        nreq = 0;
        do_reset(1'b0);
        expQ.delete();
        expQ = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int c = 0; c < 10; c++) begin
            if (c != 0) step();
            if (imem_req) begin
                nreq++;
                expVal = (expQ.size() != 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
                checks++; if (imem_addr !== expVal) begin failures++; $display("[TB] FAIL bp_req_addr got=%h exp=%h", imem_addr, expVal); end
            end
        end
        checks++; if (nreq != 4) begin failures++; $display("[TB] FAIL bp_req_count got=%0d exp=4", nreq); end
        checks++; if (dut.u_queue.count_o !== 3'd4) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=4", dut.u_queue.count_o); end
        out_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL bp_pop_req got=%b exp=0", imem_req); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("[TB] FAIL bp_pop_pc got=%h exp=0", out_pc); end
        step();
        out_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL bp_refill_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("[TB] FAIL bp_refill_addr got=%h exp=10", imem_addr); end
        checks++; if (out_pc !== 32'h4) begin failures++; $display("[TB] FAIL bp_head_pc got=%h exp=4", out_pc); end
        expQ = '{32'h4, 32'h8, 32'hC, 32'h10};
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
            if (out_valid) begin
                expVal = expQ.pop_front();
                checks++; if (out_pc !== expVal) begin failures++; $display("[TB] FAIL bp_drain_pc got=%h exp=%h", out_pc, expVal); end
                checks++; if (out_instr !== expVal) begin failures++; $display("[TB] FAIL bp_drain_instr got=%h exp=%h", out_instr, expVal); end
            end
            step();
        end
        checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL bp_drain_timeout got=%0d left exp=0", expQ.size()); end
    endtask

    task automatic test_branch();
        do_reset(1'b1);
        for (int c = 1; c <= 5; c++) step();
        branch_taken = 1'b1; branch_target = 32'h100;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL br_req got=%b exp=0", imem_req); end
        step();
        branch_taken = 1'b0; branch_target = 32'h0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL br_flush got=%b exp=0", out_valid); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL br_n1_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL br_n1_addr got=%h exp=100", imem_addr); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL br_stale got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL br_n3_valid got=%b exp=1", out_valid); end
        expQ.delete();
        expQ = '{32'h100, 32'h104, 32'h108};
        for (int c = 0; c < 10 && expQ.size() != 0; c++) begin
            if (out_valid) begin
                expVal = expQ.pop_front();
                checks++; if (out_pc !== expVal) begin failures++; $display("[TB] FAIL br_pc got=%h exp=%h", out_pc, expVal); end
                checks++; if (out_pc4 !== expVal + 32'd4) begin failures++; $display("[TB] FAIL br_pc4 got=%h exp=%h", out_pc4, expVal + 32'd4); end
            end
            step();
        end
        checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL br_timeout got=%0d left exp=0", expQ.size()); end
    endtask

    task automatic test_priority();
        do_reset(1'b1);
        for (int c = 1; c <= 4; c++) step();
        branch_taken = 1'b1; branch_target = 32'h200;
        jump_taken = 1'b1; jump_target = 32'h300;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL pr_req got=%b exp=0", imem_req); end
        step();
        branch_taken = 1'b0; jump_taken = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("[TB] FAIL pr_addr got=%h exp=200", imem_addr); end
        step(); step();
        checks++; if (out_pc !== 32'h200) begin failures++; $display("[TB] FAIL pr_out_pc got=%h exp=200", out_pc); end
        jump_taken = 1'b1; jump_target = 32'h303;
        #1;
        step();
        jump_taken = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h300) begin failures++; $display("[TB] FAIL jmp_addr got=%h exp=300", imem_addr); end
        step(); step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL jmp_valid got=%b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h300) begin failures++; $display("[TB] FAIL jmp_pc got=%h exp=300", out_pc); end
        checks++; if (out_pc4 !== 32'h304) begin failures++; $display("[TB] FAIL jmp_pc4 got=%h exp=304", out_pc4); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        step(); step();
        expQ.delete();
        expQ = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        for (int c = 0; c < 3; c++) begin
            expVal = expQ.pop_front();
            checks++; if (out_valid_w !== 1'b1) begin failures++; $display("[TB] FAIL wr_valid got=%b exp=1", out_valid_w); end
            checks++; if (out_pc_w !== expVal) begin failures++; $display("[TB] FAIL wr_pc got=%h exp=%h", out_pc_w, expVal); end
            checks++; if (out_pc4_w !== expVal + 32'd4) begin failures++; $display("[TB] FAIL wr_pc4 got=%h exp=%h", out_pc4_w, expVal + 32'd4); end
            checks++; if (out_instr_w !== expVal) begin failures++; $display("[TB] FAIL wr_instr got=%h exp=%h", out_instr_w, expVal); end
            step();
        end
    endtask

    task automatic test_midreset();
        do_reset(1'b0);
        for (int c = 1; c <= 6; c++) step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mr_full_valid got=%b exp=1", out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL mr_req_low got=%b exp=0", imem_req); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mr_valid got=%b exp=0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL mr_addr got=%h exp=0", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL mr_req got=%b exp=1", imem_req); end
        out_ready = 1'b1;
        #1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mr_c1_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mr_c2_valid got=%b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("[TB] FAIL mr_c2_pc got=%h exp=0", out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_priority();
        test_wrap();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
